// File: rtl/shader_alu_pkg.sv
// Shared definitions for the shader-core ALU issue path: op encoding,
// default latencies and the writeback scoreboard entry type.
package shader_alu_pkg;

   // in_op[OP_DIV] set selects the divide path; otherwise [1:0] is the FMA sub-op
   localparam int OP_DIV = 2;

   localparam logic [1:0] SUB_FMA = 2'd0;
   localparam logic [1:0] SUB_MUL = 2'd1;
   localparam logic [1:0] SUB_ADD = 2'd2;
   localparam logic [1:0] SUB_MAX = 2'd3;

   localparam int FMA_LAT_DEF = 15;
   localparam int DIV_LAT_DEF = 14;

   // Field widths of the scoreboard entry; match the top-level defaults
   localparam int TAG_W = 6;
   localparam int GRP_W = 2;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             div;
      logic [GRP_W-1:0] grp;
      logic             last;
   } wb_slot_t;

endpackage

// File: rtl/alu_wb_slots.sv
// Aging writeback scoreboard: FMA_LAT-1 shift entries plus the output register.
// Ports: clk_i/rst_ni, book_i/book_div_i/book_slot_i (book port),
// fma_free_o/div_free_o (due-slot-free queries), due_o (entry on ALU output now).
module alu_wb_slots
   import shader_alu_pkg::*;
#(
   parameter int FMA_LAT_P = FMA_LAT_DEF,
   parameter int DIV_LAT_P = DIV_LAT_DEF
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     book_i,
   input  logic     book_div_i,
   input  wb_slot_t book_slot_i,
   output logic     fma_free_o,
   output logic     div_free_o,
   output wb_slot_t due_o
);

   // sr_q[k] reaches the output register k+1 edges from now, so an issue
   // with latency L is booked at index L-2.
   localparam int D      = FMA_LAT_P - 1;
   localparam int FMA_IX = FMA_LAT_P - 2;
   localparam int DIV_IX = DIV_LAT_P - 2;

   wb_slot_t sr_q [D];
   wb_slot_t sr_d [D];
   wb_slot_t due_q;

   // Nothing is ever booked further out than FMA_LAT, so the FMA slot is free
   assign fma_free_o = 1'b1;

   // The entry now at DIV_IX+1 is the one that would share the divide slot
   generate
      if (DIV_IX + 1 < D) begin : g_div_q
         assign div_free_o = !sr_q[DIV_IX+1].valid;
      end else begin : g_div_top
         assign div_free_o = 1'b1;
      end
   endgenerate

   always_comb begin
      for (int i = 0; i < D; i++) sr_d[i] = '0;
      for (int i = 0; i < D - 1; i++) sr_d[i] = sr_q[i+1];
      if (book_i) begin
         if (book_div_i) sr_d[DIV_IX] = book_slot_i;
         else            sr_d[FMA_IX] = book_slot_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < D; i++) sr_q[i] <= '0;
         due_q <= '0;
      end else begin
         for (int i = 0; i < D; i++) sr_q[i] <= sr_d[i];
         due_q <= sr_q[0];
      end
   end

   assign due_o = due_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts 16-lane ops, splits divides into beats, books
// collision-free output slots and emits tagged writeback strobes.
// Ports: in_* request handshake, alu_* issue to ALU, wb_* writeback, perf_*.
// Build option ALU_ISSUE_PERF_EN enables perf_ops/perf_stalls (else tied 0).
module alu_issue_ctrl
   import shader_alu_pkg::*;
#(
   parameter int FMA_WIDTH = 16,
   parameter int DIV_WIDTH = 4,
   parameter int TAG_WIDTH = 6,
   parameter int FMA_LAT   = FMA_LAT_DEF,
   parameter int DIV_LAT   = DIV_LAT_DEF
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [2:0]                                in_op,
   input  logic [TAG_WIDTH-1:0]                      in_tag,
   output logic                                      alu_issue,
   output logic [2:0]                                alu_op,
   output logic [$clog2(FMA_WIDTH/DIV_WIDTH)-1:0]    alu_grp,
   output logic                                      wb_valid,
   output logic [TAG_WIDTH-1:0]                      wb_tag,
   output logic                                      wb_div,
   output logic [$clog2(FMA_WIDTH/DIV_WIDTH)-1:0]    wb_grp,
   output logic                                      wb_last,
   output logic [31:0]                               perf_ops,
   output logic [31:0]                               perf_stalls
);

   localparam int N  = FMA_WIDTH / DIV_WIDTH;
   localparam int GW = $clog2(N);
   localparam logic [GW-1:0] LAST_BEAT = GW'(N - 1);

   typedef enum logic {IDLE, DIV_SEQ} state_e;

   state_e           state_q, state_d;
   logic [GW-1:0]    beat_q, beat_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [2:0]       op_q, op_d;

   logic     fma_free, div_free;
   logic     accept, book, book_div;
   wb_slot_t slot, due;

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      tag_d    = tag_q;
      op_d     = op_q;
      in_ready = 1'b0;
      accept   = 1'b0;
      book     = 1'b0;
      book_div = 1'b0;
      alu_op   = '0;
      alu_grp  = '0;
      slot     = '0;
      // Comb outputs are forced low while reset is held
      if (rst) begin
         unique case (state_q)
            IDLE: begin
               in_ready = in_op[OP_DIV] ? div_free : fma_free;
               accept   = in_valid && in_ready;
               if (accept) begin
                  book       = 1'b1;
                  book_div   = in_op[OP_DIV];
                  alu_op     = in_op;
                  slot.valid = 1'b1;
                  slot.tag   = in_tag;
                  slot.div   = in_op[OP_DIV];
                  slot.last  = !in_op[OP_DIV] || (N == 1);
                  if (in_op[OP_DIV] && N > 1) begin
                     state_d = DIV_SEQ;
                     beat_d  = GW'(1);
                     tag_d   = in_tag;
                     op_d    = in_op;
                  end
               end
            end
            DIV_SEQ: begin
               // A beat whose slot is taken simply waits a cycle
               if (div_free) begin
                  book       = 1'b1;
                  book_div   = 1'b1;
                  alu_op     = op_q;
                  alu_grp    = beat_q;
                  slot.valid = 1'b1;
                  slot.tag   = tag_q;
                  slot.div   = 1'b1;
                  slot.grp   = beat_q;
                  slot.last  = (beat_q == LAST_BEAT);
                  if (beat_q == LAST_BEAT) state_d = IDLE;
                  else                     beat_d  = beat_q + GW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_issue = book;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         tag_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tag_q   <= tag_d;
         op_q    <= op_d;
      end
   end

   alu_wb_slots #(
      .FMA_LAT_P (FMA_LAT),
      .DIV_LAT_P (DIV_LAT)
   ) u_slots (
      .clk_i       (clk),
      .rst_ni      (rst),
      .book_i      (book),
      .book_div_i  (book_div),
      .book_slot_i (slot),
      .fma_free_o  (fma_free),
      .div_free_o  (div_free),
      .due_o       (due)
   );

   assign wb_valid = due.valid;
   assign wb_tag   = due.tag;
   assign wb_div   = due.div;
   assign wb_grp   = due.grp;
   assign wb_last  = due.last;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] ops_q, stalls_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ops_q    <= '0;
         stalls_q <= '0;
      end else begin
         ops_q    <= ops_q + 32'(accept);
         stalls_q <= stalls_q + 32'(in_valid && !in_ready);
      end
   end

   assign perf_ops    = ops_q;
   assign perf_stalls = stalls_q;
`else
   assign perf_ops    = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic against
// a cycle-calendar reference model.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [5:0]  in_tag;
   logic        alu_issue;
   logic [2:0]  alu_op;
   logic [1:0]  alu_grp;
   logic        wb_valid;
   logic [5:0]  wb_tag;
   logic        wb_div;
   logic [1:0]  wb_grp;
   logic        wb_last;
   logic [31:0] perf_ops;
   logic [31:0] perf_stalls;

   alu_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_tag      (in_tag),
      .alu_issue   (alu_issue),
      .alu_op      (alu_op),
      .alu_grp     (alu_grp),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .wb_div      (wb_div),
      .wb_grp      (wb_grp),
      .wb_last     (wb_last),
      .perf_ops    (perf_ops),
      .perf_stalls (perf_stalls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @t=%0t: got %0h expected %0h",
                    nm, $time, got, exp);
   endtask

   // Reference model: calendar of expected writebacks keyed by absolute cycle
   // {last, grp[1:0], div, tag[5:0]}
   logic [9:0]  cal [int];
   int          cyc;
   bit          in_div;
   int          beat;
   logic [5:0]  dtag;
   logic [2:0]  dop;
   int          m_ops;
   int          m_stalls;

   task automatic step(input logic v, input logic [2:0] op,
                       input logic [5:0] tg);
      logic       er, ei;
      logic [2:0] eop;
      logic [1:0] eg;
      int         due;
      in_valid = v;
      in_op    = op;
      in_tag   = tg;
      #2;
      er = 1'b0; ei = 1'b0; eop = '0; eg = '0;
      if (!in_div) begin
         due = cyc + (op[2] ? 14 : 15);
         er  = !cal.exists(due);
         if (v && er) begin
            ei  = 1'b1;
            eop = op;
            cal[due] = {~op[2], 2'd0, op[2], tg};
            m_ops++;
            if (op[2]) begin
               in_div = 1'b1; beat = 1; dtag = tg; dop = op;
            end
         end
      end else begin
         due = cyc + 14;
         if (!cal.exists(due)) begin
            ei  = 1'b1;
            eop = dop;
            eg  = beat[1:0];
            cal[due] = {beat == 3, eg, 1'b1, dtag};
            beat++;
            if (beat == 4) in_div = 1'b0;
         end
      end
      if (v && !er) m_stalls++;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("alu_issue", 32'(alu_issue), 32'(ei));
      if (ei) begin
         chk("alu_op", 32'(alu_op), 32'(eop));
         chk("alu_grp", 32'(alu_grp), 32'(eg));
      end
      if (cal.exists(cyc)) begin
         chk("wb_valid", 32'(wb_valid), 32'd1);
         chk("wb_fields", 32'({wb_last, wb_grp, wb_div, wb_tag}),
             32'(cal[cyc]));
         cal.delete(cyc);
      end else begin
         chk("wb_idle", 32'(wb_valid), 32'd0);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 6'd0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      in_valid = 1'b0; in_op = '0; in_tag = '0;
      for (int i = 0; i < n; i++) begin
         #2;
         chk("rst_ready", 32'(in_ready), 32'd0);
         chk("rst_issue", 32'(alu_issue), 32'd0);
         chk("rst_wb", 32'({wb_valid, wb_tag, wb_div, wb_grp, wb_last}),
             32'd0);
         chk("rst_perf", perf_ops | perf_stalls, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      cal.delete();
      in_div = 1'b0; cyc = 0; m_ops = 0; m_stalls = 0;
   endtask

   task automatic chk_perf();
`ifdef ALU_ISSUE_PERF_EN
      chk("perf_ops", perf_ops, 32'(m_ops));
      chk("perf_stalls", perf_stalls, 32'(m_stalls));
`else
      chk("perf_ops_off", perf_ops, 32'd0);
      chk("perf_stalls_off", perf_stalls, 32'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_tag = '0;
      cyc = 0; in_div = 1'b0; beat = 0; dtag = '0; dop = '0;
      m_ops = 0; m_stalls = 0;
      @(negedge clk);
      do_reset(3);

      // single FMA, then a divide
      step(1'b1, 3'b000, 6'd5);
      idle(20);
      step(1'b1, 3'b100, 6'd9);
      idle(22);

      // FMA followed by a divide whose first slot collides
      step(1'b1, 3'b000, 6'd1);
      step(1'b1, 3'b100, 6'd2);
      step(1'b1, 3'b100, 6'd2);
      idle(25);

      // streaming FMAs
      do_reset(1);
      for (int i = 0; i < 20; i++) step(1'b1, 3'(i % 4), 6'(i));
      idle(20);
      chk_perf();

      // reset while a divide is in flight
      do_reset(1);
      step(1'b1, 3'b100, 6'd9);
      idle(4);
      do_reset(2);
      idle(30);

      // random traffic with one reset in the middle
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            chk_perf();
            do_reset(2);
         end
         step(($urandom % 4) != 0,
              {($urandom % 4) == 0, 2'($urandom)},
              6'($urandom));
      end
      idle(20);
      chk_perf();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
